// File: rtl/lcd1604_pkg.sv
// Shared definitions for the LCD1604 bus: instruction opcode masks,
// DDRAM address-map constants, error-flag bit positions and the
// address-counter helpers used by both controller and responder.
package lcd1604_pkg;

  // Instruction class is selected by the highest set bit of the byte.
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [6:0] LINE0_LAST = 7'h27;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h67;
  localparam logic [6:0] ROW2_BASE  = 7'h10;
  localparam logic [6:0] ROW3_BASE  = 7'h50;
  localparam int unsigned DDRAM_LINE_LEN = 40;
  localparam int unsigned DDRAM_CELLS    = 2 * DDRAM_LINE_LEN;

  localparam int unsigned ERR_READ    = 0;
  localparam int unsigned ERR_BUSY    = 1;
  localparam int unsigned ERR_ILLEGAL = 2;

  // Step the DDRAM address counter; the two 40-byte lines form one ring.
  function automatic logic [6:0] ddram_step(input logic [6:0] addr, input logic inc);
    if (inc) begin
      if (addr == LINE0_LAST) return LINE1_BASE;
      if (addr == LINE1_LAST) return '0;
      return addr + 7'd1;
    end
    if (addr == '0) return LINE1_LAST;
    if (addr == LINE1_BASE) return LINE0_LAST;
    return addr - 7'd1;
  endfunction

  function automatic logic ddram_addr_legal(input logic [6:0] addr);
    return !((addr > LINE0_LAST && addr < LINE1_BASE) || addr > LINE1_LAST);
  endfunction

  // Linear storage index 0..79 for a legal DDRAM address.
  function automatic logic [6:0] ddram_index(input logic [6:0] addr);
    if (addr < LINE1_BASE) return addr;
    return addr - LINE1_BASE + 7'(DDRAM_LINE_LEN);
  endfunction

endpackage

// File: rtl/lcd1604_bus_responder_sync.sv
// lcd_bus_sync: synchronizes the asynchronous LCD bus into clk and
// detects the falling edge of enable.
//   clk, reset          : system clock, synchronous active-high reset
//   rs, rw, enable, data: raw bus inputs
//   strobe              : one-cycle pulse, registered after the falling edge
//   cap_rs/cap_rw/cap_data: bus fields sampled while enable was still high
module lcd_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data,
  output logic       strobe,
  output logic       cap_rs,
  output logic       cap_rw,
  output logic [7:0] cap_data
);

  logic [SYNC_STAGES-1:0] rs_sync;
  logic [SYNC_STAGES-1:0] rw_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   en_prev;
  logic                   en_now;

  assign en_now = en_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_sync  <= '0;
      rw_sync  <= '0;
      en_sync  <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      en_prev  <= 1'b0;
      strobe   <= 1'b0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= '0;
    end else begin
      rs_sync[0]   <= rs;
      rw_sync[0]   <= rw;
      en_sync[0]   <= enable;
      data_sync[0] <= data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        rs_sync[i]   <= rs_sync[i-1];
        rw_sync[i]   <= rw_sync[i-1];
        en_sync[i]   <= en_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      en_prev <= en_now;
      strobe  <= en_prev & ~en_now;
      // Capture only while enable is high so post-edge hold time is irrelevant.
      if (en_now) begin
        cap_rs   <= rs_sync[SYNC_STAGES-1];
        cap_rw   <= rw_sync[SYNC_STAGES-1];
        cap_data <= data_sync[SYNC_STAGES-1];
      end
    end
  end

endmodule

// File: rtl/lcd1604_bus_responder.sv
// lcd1604_bus_responder: HD44780-compatible receiver of the 8-bit LCD1604 bus.
// Mirrors DDRAM (80 bytes) and display-control state, exposes a 4x16 read port.
//   clk, reset            : system clock, synchronous active-high reset
//   rs, rw, enable, data  : LCD bus (byte latched on enable falling edge)
//   rd_row, rd_col        : read-port coordinates; rd_char 1 cycle later
//   cmd_valid, char_valid : one-cycle pulses per accepted instruction / DDRAM write
//   last_byte, addr_ctr   : most recent accepted byte, DDRAM address counter
//   disp_on, busy         : display-on bit, Clear fill in progress
//   init_done, err_flags  : sticky init-complete and error bits (read, busy, illegal)
module lcd1604_bus_responder
  import lcd1604_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CLEAR_CYCLES = 80,
  parameter logic [7:0]  FILL_CHAR    = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic [1:0] rd_row,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char,
  output logic       cmd_valid,
  output logic       char_valid,
  output logic [7:0] last_byte,
  output logic [6:0] addr_ctr,
  output logic       disp_on,
  output logic       busy,
  output logic       init_done,
  output logic [2:0] err_flags
);

  localparam int unsigned CW = $clog2(CLEAR_CYCLES);
  localparam logic [CW-1:0] FILL_LAST = CW'(CLEAR_CYCLES - 1);

  logic          strobe;
  logic          cap_rs;
  logic          cap_rw;
  logic [7:0]    cap_data;
  logic          id_inc;
  logic          cgram_mode;
  logic          fs_armed;
  logic [1:0]    cursor_blink_unused;
  logic          fill_req;
  logic [CW-1:0] fill_cnt;
  logic [7:0]    mem [DDRAM_CELLS];
  logic          mem_we;
  logic [6:0]    mem_idx;
  logic [7:0]    mem_wdata;
  logic [6:0]    rd_base;
  logic [6:0]    rd_idx;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .rs       (rs),
    .rw       (rw),
    .enable   (enable),
    .data     (data),
    .strobe   (strobe),
    .cap_rs   (cap_rs),
    .cap_rw   (cap_rw),
    .cap_data (cap_data)
  );

  // Single DDRAM write port: fill engine and character writes never overlap,
  // because character writes are refused while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (busy && fill_cnt < CW'(DDRAM_CELLS)) begin
        mem_we    = 1'b1;
        mem_idx   = 7'(fill_cnt);
        mem_wdata = FILL_CHAR;
      end else if (strobe && !cap_rw && !busy && cap_rs && !cgram_mode) begin
        mem_we    = 1'b1;
        mem_idx   = ddram_index(addr_ctr);
        mem_wdata = cap_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_comb begin
    case (rd_row)
      2'd0:    rd_base = '0;
      2'd1:    rd_base = LINE1_BASE;
      2'd2:    rd_base = ROW2_BASE;
      default: rd_base = ROW3_BASE;
    endcase
    rd_idx = ddram_index(rd_base + {3'b000, rd_col});
  end

  always_ff @(posedge clk) begin
    if (reset) rd_char <= FILL_CHAR;
    else       rd_char <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_ctr            <= '0;
      disp_on             <= 1'b0;
      busy                <= 1'b0;
      init_done           <= 1'b0;
      err_flags           <= '0;
      cmd_valid           <= 1'b0;
      char_valid          <= 1'b0;
      last_byte           <= '0;
      id_inc              <= 1'b1;
      cgram_mode          <= 1'b0;
      fs_armed            <= 1'b0;
      cursor_blink_unused <= '0;
      fill_cnt            <= '0;
      fill_req            <= 1'b1;
    end else begin
      cmd_valid  <= 1'b0;
      char_valid <= 1'b0;

      // Fill is requested during reset and launched on the first free cycle.
      if (fill_req) begin
        fill_req <= 1'b0;
        busy     <= 1'b1;
        fill_cnt <= '0;
      end else if (busy) begin
        if (fill_cnt == FILL_LAST) busy <= 1'b0;
        fill_cnt <= fill_cnt + 1'b1;
      end

      if (strobe) begin
        if (cap_rw) begin
          err_flags[ERR_READ] <= 1'b1;
        end else if (busy) begin
          err_flags[ERR_BUSY] <= 1'b1;
        end else if (cap_rs) begin
          last_byte <= cap_data;
          if (cgram_mode) begin
            err_flags[ERR_ILLEGAL] <= 1'b1;
          end else begin
            char_valid <= 1'b1;
            addr_ctr   <= ddram_step(addr_ctr, id_inc);
          end
        end else begin
          last_byte <= cap_data;
          cmd_valid <= 1'b1;
          if ((cap_data & OP_DDRAM) != '0) begin
            if (ddram_addr_legal(cap_data[6:0])) begin
              addr_ctr   <= cap_data[6:0];
              cgram_mode <= 1'b0;
            end else begin
              err_flags[ERR_ILLEGAL] <= 1'b1;
            end
          end else if ((cap_data & OP_CGRAM) != '0) begin
            cgram_mode <= 1'b1;
          end else if ((cap_data & OP_FUNC) != '0) begin
            if (cap_data[4]) fs_armed <= 1'b1;
            else             err_flags[ERR_ILLEGAL] <= 1'b1;
          end else if ((cap_data & OP_SHIFT) != '0) begin
            if (!cap_data[3]) addr_ctr <= ddram_step(addr_ctr, cap_data[2]);
          end else if ((cap_data & OP_DISPLAY) != '0) begin
            disp_on             <= cap_data[2];
            cursor_blink_unused <= cap_data[1:0];
            if (cap_data[2] && fs_armed) init_done <= 1'b1;
          end else if ((cap_data & OP_ENTRY) != '0) begin
            id_inc <= cap_data[1];
          end else if ((cap_data & OP_HOME) != '0) begin
            addr_ctr <= '0;
          end else if ((cap_data & OP_CLEAR) != '0) begin
            addr_ctr <= '0;
            id_inc   <= 1'b1;
            busy     <= 1'b1;
            fill_cnt <= '0;
          end
        end
      end
    end
  end

endmodule
